// File: rtl/pmp_pkg.sv
// Shared phase-processing constants and width helpers.
package pmp_pkg;

  // Native wrapped-phase resolution: 2^PMP_PHASE_BITS codes span one full turn.
  localparam int unsigned PMP_PHASE_BITS = 16;

  // Code count for a full turn (2*pi) at a given phase width.
  function automatic longint unsigned pmp_two_pi(input int unsigned width);
    return longint'(1) << width;
  endfunction

  // Code for a half turn (pi); a difference of exactly this value reads as -pi.
  function automatic longint unsigned pmp_pi(input int unsigned width);
    return longint'(1) << (width - 1);
  endfunction

  // Unwrapped-phase width: wrapped bits plus extra turn-counting bits.
  function automatic int unsigned pmp_uw(input int unsigned data_width,
                                         input int unsigned wrap_bits);
    return data_width + wrap_bits;
  endfunction

endpackage

// File: rtl/phase_lane_delta.sv
// Signed modular difference of two wrapped phases (cur - prev), one lane.
module phase_lane_delta
  import pmp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PMP_PHASE_BITS
) (
  input  logic        [DATA_WIDTH-1:0] i_cur,
  input  logic        [DATA_WIDTH-1:0] i_prev,
  output logic signed [DATA_WIDTH-1:0] o_delta_c
);

  logic [DATA_WIDTH-1:0] w_diff;

  // Modular subtraction; the two's complement view makes a half-turn read as -pi.
  assign w_diff    = i_cur - i_prev;
  assign o_delta_c = $signed(w_diff);

endmodule

// File: rtl/phase_row_unwrap.sv
// Row-wise phase unwrapper: stage 1 forms in-beat prefix sums, stage 2 adds the row base.
module phase_row_unwrap
  import pmp_pkg::*;
#(
  parameter int unsigned BEAT_SIZE  = 8,
  parameter int unsigned DATA_WIDTH = PMP_PHASE_BITS,
  parameter int unsigned IMG_WIDTH  = 1280,
  parameter int unsigned WRAP_BITS  = 8
) (
  input  logic                                                aclk,
  input  logic                                                aresetn,
  input  logic [BEAT_SIZE*DATA_WIDTH-1:0]                     s_axis_tdata,
  input  logic                                                s_axis_tvalid,
  output logic                                                s_axis_tready,
  input  logic                                                s_axis_tlast,
  output logic [BEAT_SIZE*pmp_uw(DATA_WIDTH, WRAP_BITS)-1:0]  m_axis_tdata,
  output logic                                                m_axis_tvalid,
  input  logic                                                m_axis_tready,
  output logic                                                m_axis_tlast,
  output logic                                                m_axis_tuser,
  output logic                                                err_row
);

  localparam int unsigned UW        = pmp_uw(DATA_WIDTH, WRAP_BITS);
  localparam int unsigned BEATS     = IMG_WIDTH / BEAT_SIZE;
  localparam int unsigned CW        = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  function automatic logic [UW-1:0] sext(input logic [DATA_WIDTH-1:0] d);
    return UW'($signed(d));
  endfunction

  logic                                  w_adv;
  logic                                  w_accept;
  logic [BEAT_SIZE-1:0][DATA_WIDTH-1:0]  w_pix;
  logic [BEAT_SIZE-1:0][DATA_WIDTH-1:0]  w_prev;
  logic [BEAT_SIZE-1:0][DATA_WIDTH-1:0]  w_delta;
  logic [BEAT_SIZE-1:0][UW-1:0]          w_sum;
  logic [BEAT_SIZE-1:0][UW-1:0]          w_out;
  logic [UW-1:0]                         w_base;

  logic [DATA_WIDTH-1:0]                 r_prev_phase;
  logic [CW-1:0]                         r_cnt;
  logic                                  r_row_start;
  logic                                  r_err;
  logic                                  r_s1_valid;
  logic [BEAT_SIZE-1:0][UW-1:0]          r_s1_sum;
  logic                                  r_s1_row_start;
  logic                                  r_s1_last;
  logic [UW-1:0]                         r_base;

  // One enable moves the whole pipeline; nothing advances while the output is stuck.
  assign w_pix         = s_axis_tdata;
  assign w_adv         = ~m_axis_tvalid | m_axis_tready;
  assign s_axis_tready = w_adv;
  assign w_accept      = s_axis_tvalid & w_adv;
  assign err_row       = r_err;

  for (genvar g = 0; g < BEAT_SIZE; g++) begin : g_lane
    if (g == 0) begin : g_first
      assign w_prev[g] = r_prev_phase;
    end else begin : g_rest
      assign w_prev[g] = w_pix[g-1];
    end
    phase_lane_delta #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_delta (
      .i_cur     (w_pix[g]),
      .i_prev    (w_prev[g]),
      .o_delta_c (w_delta[g])
    );
  end

  // In-beat prefix sums; a row start seeds lane 0 with the raw phase instead of a delta.
  always_comb begin
    logic [UW-1:0] acc;
    w_sum = '0;
    acc   = r_row_start ? UW'(w_pix[0]) : sext(w_delta[0]);
    w_sum[0] = acc;
    for (int i = 1; i < BEAT_SIZE; i++) begin
      acc      = acc + sext(w_delta[i]);
      w_sum[i] = acc;
    end
  end

  // Row tracking: beat counter, carried raw phase and the sticky frame-length error.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_prev_phase <= '0;
      r_cnt        <= '0;
      r_row_start  <= 1'b1;
      r_err        <= 1'b0;
    end else if (w_accept) begin
      r_prev_phase <= w_pix[BEAT_SIZE-1];
      if (s_axis_tlast) begin
        r_cnt       <= '0;
        r_row_start <= 1'b1;
        if (r_cnt != LAST_BEAT) begin
          r_err <= 1'b1;
        end
      end else if (r_cnt == LAST_BEAT) begin
        r_cnt       <= '0;
        r_row_start <= 1'b1;
      end else begin
        r_cnt       <= r_cnt + CW'(1);
        r_row_start <= 1'b0;
      end
    end
  end

  // Stage 1 register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_s1_valid     <= 1'b0;
      r_s1_sum       <= '0;
      r_s1_row_start <= 1'b0;
      r_s1_last      <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_sum       <= w_sum;
        r_s1_row_start <= r_row_start;
        r_s1_last      <= s_axis_tlast;
      end
    end
  end

  // Stage 2: the base is the last-lane unwrapped value of the previous beat in the row.
  always_comb begin
    w_base = r_s1_row_start ? '0 : r_base;
    for (int i = 0; i < BEAT_SIZE; i++) begin
      w_out[i] = w_base + r_s1_sum[i];
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      r_base        <= '0;
    end else if (w_adv) begin
      m_axis_tvalid <= r_s1_valid;
      if (r_s1_valid) begin
        m_axis_tdata <= w_out;
        m_axis_tlast <= r_s1_last;
        m_axis_tuser <= r_s1_row_start;
        r_base       <= w_out[BEAT_SIZE-1];
      end
    end
  end

endmodule

// File: tb/tb_phase_row_unwrap.sv
// Directed + randomized bench for phase_row_unwrap against a per-pixel unwrap model.
module tb_phase_row_unwrap;

  localparam int BS  = 8;
  localparam int DW  = 16;
  localparam int IW  = 16;
  localparam int WB  = 8;
  localparam int UW  = DW + WB;
  localparam int DWB = BS * DW;
  localparam int UWB = BS * UW;

  typedef struct packed {
    logic [UWB-1:0] data;
    logic           user;
    logic           last;
    int             cyc;
  } beat_t;

  logic           aclk = 1'b0;
  logic           aresetn;
  logic [DWB-1:0] s_axis_tdata;
  logic           s_axis_tvalid;
  logic           s_axis_tready;
  logic           s_axis_tlast;
  logic [UWB-1:0] m_axis_tdata;
  logic           m_axis_tvalid;
  logic           m_axis_tready;
  logic           m_axis_tlast;
  logic           m_axis_tuser;
  logic           err_row;

  phase_row_unwrap #(
    .BEAT_SIZE (BS), .DATA_WIDTH (DW), .IMG_WIDTH (IW), .WRAP_BITS (WB)
  ) dut (
    .aclk (aclk), .aresetn (aresetn),
    .s_axis_tdata (s_axis_tdata), .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready), .s_axis_tlast (s_axis_tlast),
    .m_axis_tdata (m_axis_tdata), .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready), .m_axis_tlast (m_axis_tlast),
    .m_axis_tuser (m_axis_tuser), .err_row (err_row)
  );

  always #5 aclk = ~aclk;

  int        n_checks = 0;
  int        n_err    = 0;
  int        cyc      = 0;
  int        rdy_mode = 0;   // 0: always ready, 1: random 50%, 2: never ready
  bit        last_acc;
  bit        hold_v   = 1'b0;
  logic [UWB-1:0] hold_d;
  beat_t     exp_q[$];
  beat_t     got_q[$];

  // Model state: pixel position in row, last raw phase, running unwrapped value.
  int          mpx  = 0;
  logic [DW-1:0] mprev;
  logic [UW-1:0] mu;
  bit          merr = 1'b0;

  task automatic chk(input string tag, input logic [UWB-1:0] got, input logic [UWB-1:0] expv);
    n_checks++;
    assert (got === expv) else begin
      n_err++;
      $error("FAIL %s: got=%h exp=%h", tag, got, expv);
    end
  endtask

  function automatic logic [UW-1:0] lane(input beat_t b, input int i);
    return b.data[i*UW +: UW];
  endfunction

  // Unwrap one accepted beat pixel by pixel, straight from the row rules.
  task automatic model_accept();
    beat_t e;
    int d;
    int bpx;
    logic [DW-1:0] p;
    bpx    = mpx;
    e.user = (mpx == 0);
    e.last = s_axis_tlast;
    e.cyc  = cyc;
    e.data = '0;
    for (int i = 0; i < BS; i++) begin
      p = s_axis_tdata[i*DW +: DW];
      if (mpx == 0) begin
        mu = UW'(p);
      end else begin
        d = int'(p) - int'(mprev);
        if (d >= 32768) d -= 65536;
        else if (d < -32768) d += 65536;
        mu = UW'(int'(mu) + d);
      end
      mprev = p;
      e.data[i*UW +: UW] = mu;
      mpx++;
    end
    if (s_axis_tlast) begin
      if (bpx != IW - BS) merr = 1'b1;
      mpx = 0;
    end else if (mpx == IW) begin
      mpx = 0;
    end
    exp_q.push_back(e);
  endtask

  task automatic check_out();
    beat_t e;
    beat_t g;
    g.data = m_axis_tdata;
    g.user = m_axis_tuser;
    g.last = m_axis_tlast;
    g.cyc  = cyc;
    got_q.push_back(g);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_err++;
      $error("FAIL unexpected_beat: got=%h exp=none pending", m_axis_tdata);
    end else begin
      e = exp_q.pop_front();
      chk("out_data", g.data, e.data);
      chk("out_tuser", UWB'(g.user), UWB'(e.user));
      chk("out_tlast", UWB'(g.last), UWB'(e.last));
      if (rdy_mode == 0) chk("latency", UWB'(cyc - e.cyc), UWB'(2));
    end
  endtask

  // One clock: drive ready, sample everything on the falling edge, return after the rise.
  task automatic tick();
    last_acc = 1'b0;
    case (rdy_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = 1'($urandom_range(0, 1));
      default: m_axis_tready = 1'b0;
    endcase
    @(negedge aclk);
    cyc++;
    if (aresetn) begin
      if (hold_v) begin
        chk("hold_valid", UWB'(m_axis_tvalid), UWB'(1));
        chk("hold_data", m_axis_tdata, hold_d);
      end
      if (m_axis_tvalid && m_axis_tready) check_out();
      if (s_axis_tvalid && s_axis_tready) begin
        model_accept();
        last_acc = 1'b1;
      end
      hold_v = m_axis_tvalid && !m_axis_tready;
      hold_d = m_axis_tdata;
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic send(input logic [DWB-1:0] bd, input logic last);
    int t = 0;
    s_axis_tdata  = bd;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    do begin
      tick();
      t++;
    end while (!last_acc && t < 200);
    chk("accept_timeout", UWB'(last_acc), UWB'(1));
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    s_axis_tvalid = 1'b0;
    while (exp_q.size() != 0 && t < 400) begin
      tick();
      t++;
    end
    tick();
    chk("drain_pending", UWB'(exp_q.size()), UWB'(0));
  endtask

  task automatic do_reset(input int ncyc);
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    for (int i = 0; i < ncyc; i++) tick();
    hold_v = 1'b0;
    exp_q.delete();
    mpx  = 0;
    merr = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    logic [DWB-1:0] bd;
    aresetn       = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    @(posedge aclk);
    #1;

    // Reset state and ready after release.
    do_reset(3);
    chk("rst_tvalid", UWB'(m_axis_tvalid), UWB'(0));
    chk("rst_tlast", UWB'(m_axis_tlast), UWB'(0));
    chk("rst_tuser", UWB'(m_axis_tuser), UWB'(0));
    chk("rst_err", UWB'(err_row), UWB'(0));
    aresetn = 1'b1;
    #1;
    chk("rst_tready", UWB'(s_axis_tready), UWB'(1));

    // Ramp: 0, 0x4000, 0x8000, 0xC000 repeating.
    got_q.delete();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < BS; i++) bd[i*DW +: DW] = DW'(((b*BS + i) % 4) * 16'h4000);
      send(bd, b == 1);
    end
    drain();
    chk("ramp_b0_l1", UWB'(lane(got_q[0], 1)), UWB'(24'h004000));
    chk("ramp_b1_l7", UWB'(lane(got_q[1], 7)), UWB'(24'h03C000));
    chk("ramp_tuser0", UWB'(got_q[0].user), UWB'(1));
    chk("ramp_tuser1", UWB'(got_q[1].user), UWB'(0));

    // Descending wrap and the exact half-turn delta.
    got_q.delete();
    for (int i = 0; i < BS; i++) bd[i*DW +: DW] = 16'h7000;
    bd[0*DW +: DW] = 16'h1000;
    bd[1*DW +: DW] = 16'hF000;
    send(bd, 1'b0);
    for (int i = 0; i < BS; i++) bd[i*DW +: DW] = 16'h7000;
    send(bd, 1'b1);
    drain();
    chk("wrap_l0", UWB'(lane(got_q[0], 0)), UWB'(24'h001000));
    chk("wrap_l1", UWB'(lane(got_q[0], 1)), UWB'(24'hFFF000));
    chk("wrap_halfturn", UWB'(lane(got_q[0], 2)), UWB'(24'hFF7000));

    // Row 1 ends at 0x030000, row 2 restarts from its raw first pixel.
    got_q.delete();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < BS; i++) bd[i*DW +: DW] = DW'((b*BS + i + 1) * 16'h3000);
      send(bd, 1'b0);
    end
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < BS; i++) bd[i*DW +: DW] = 16'h2000;
      send(bd, b == 1);
    end
    drain();
    chk("row1_end", UWB'(lane(got_q[1], 7)), UWB'(24'h030000));
    chk("row2_start", UWB'(lane(got_q[2], 0)), UWB'(24'h002000));
    chk("row2_tuser", UWB'(got_q[2].user), UWB'(1));

    // Random pixels, random bubbles, 50% output backpressure.
    rdy_mode = 1;
    for (int f = 0; f < 4; f++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          s_axis_tvalid = 1'b0;
          repeat ($urandom_range(1, 2)) tick();
        end
        for (int i = 0; i < BS; i++) bd[i*DW +: DW] = DW'($urandom);
        send(bd, b == 3);
      end
    end
    drain();
    rdy_mode = 0;
    chk("rand_err", UWB'(err_row), UWB'(0));

    // Short frame: tlast on beat 0 of a row.
    got_q.delete();
    for (int i = 0; i < BS; i++) bd[i*DW +: DW] = DW'($urandom);
    send(bd, 1'b1);
    drain();
    chk("short_err", UWB'(err_row), UWB'(1));
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < BS; i++) bd[i*DW +: DW] = DW'($urandom);
      send(bd, b == 1);
    end
    drain();
    chk("short_err_sticky", UWB'(err_row), UWB'(merr));
    chk("short_next_tuser", UWB'(got_q[1].user), UWB'(1));

    // Reset mid-row with beats in flight.
    got_q.delete();
    rdy_mode = 2;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < BS; i++) bd[i*DW +: DW] = DW'($urandom);
      send(bd, 1'b0);
    end
    do_reset(1);
    chk("midrst_tvalid", UWB'(m_axis_tvalid), UWB'(0));
    chk("midrst_err", UWB'(err_row), UWB'(0));
    aresetn  = 1'b1;
    rdy_mode = 0;
    for (int i = 0; i < BS; i++) bd[i*DW +: DW] = DW'(16'h0500 + i * 16'h0100);
    send(bd, 1'b0);
    drain();
    chk("midrst_count", UWB'(got_q.size()), UWB'(1));
    chk("midrst_tuser", UWB'(got_q[0].user), UWB'(1));
    chk("midrst_l0", UWB'(lane(got_q[0], 0)), UWB'(24'h000500));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
